bcd_conv_arbiter: RTL and testbench
===================================

# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-BCD converter (13-bit binary in, 4 BCD digits out, start/data-valid handshake) among several requesters, e.g. display channels for PC, accumulator and memory data. It sits between the requesters and the converter. It captures the granted requester's binary value, issues a single-cycle start, waits for the converter's data-valid, and returns the BCD result with a per-requester done pulse. A watchdog guards against a converter that never answers.

## Interface
- N_REQ, 4, number of requesters (2..8)
- BIN_W, 13, binary operand width
- DIGITS, 4, BCD digits in result
- TIMEOUT_CYC, 255, maximum cycles spent in WAIT before abort (nominal converter latency ≈123 cycles)

- i_Clock  in  1  single clock; all logic on posedge
- i_Reset_n  in  1  reset, asynchronous, active-low
- i_Req  in  N_REQ  level request per requester; held until own o_Done
- i_Binary_Bus  in  N_REQ*BIN_W  operand of requester k at [k*BIN_W +: BIN_W]
- o_Grant  out  N_REQ  one-hot, high from grant until completion
- o_Done  out  N_REQ  one-cycle pulse to the served requester when o_BCD is valid
- o_BCD  out  DIGITS*4  last result, held until next completion
- o_Timeout  out  1  one-cycle pulse, coincident with o_Done, on watchdog abort
- o_Busy  out  1  high whenever state ≠ IDLE
- o_Conv_Binary  out  BIN_W  operand to converter, stable from grant until completion
- o_Conv_Start  out  1  one-cycle start pulse to converter
- i_Conv_BCD  in  DIGITS*4  converter result
- i_Conv_DV  in  1  converter data-valid, one cycle

## Operation
- States: IDLE, START, WAIT, DONE. All outputs registered.
- IDLE: if any i_Req bit set, pick the winner by round-robin. Search starts at r_Last+1 and wraps modulo N_REQ. Then: o_Grant ← onehot(winner), o_Conv_Binary ← winner's slice, o_Conv_Start ← 1, r_Last ← winner, go START. Otherwise stay.
- START: o_Conv_Start ← 0, clear watchdog, go WAIT.
- WAIT: watchdog increments each cycle.
  - i_Conv_DV=1: o_BCD ← i_Conv_BCD, o_Done[winner] ← 1, o_Grant ← 0, go DONE.
  - Otherwise, when watchdog reaches TIMEOUT_CYC: o_BCD ← {DIGITS{4'hF}}, o_Done[winner] ← 1, o_Timeout ← 1, o_Grant ← 0, go DONE.
  - If DV and terminal count coincide, DV wins and there is no timeout.
- DONE: o_Done ← 0, o_Timeout ← 0, go IDLE. This state guarantees the converter has returned to its idle state before the next start.
- i_Conv_DV outside WAIT is ignored (late DV after a timeout, or a conversion in flight across reset).
- i_Req dropping while granted does not abort: the conversion completes and o_Done still pulses.
- Requester contract: i_Req low by the second rising edge after o_Done rises. Otherwise the request counts as new and waits its round-robin turn.
- Requests arriving in START/WAIT/DONE wait. They are evaluated in IDLE only.
- Watchdog width: $clog2(TIMEOUT_CYC+1); it saturates, never wraps.
- Reset (async, any state, including mid-WAIT):
  - state=IDLE, r_Last=N_REQ-1 (requester 0 wins first).
  - o_Grant=0, o_Done=0, o_BCD=0, o_Timeout=0, o_Busy=0, o_Conv_Binary=0, o_Conv_Start=0, watchdog=0.

## Timing
- Edge t: IDLE samples request. During cycle t..t+1: o_Grant, o_Conv_Binary and o_Conv_Start=1 are visible. The converter samples start at edge t+1.
- o_Conv_Start is high for exactly one cycle per grant.
- DV sampled at edge m: o_BCD/o_Done valid in cycle m..m+1. State is IDLE after edge m+1. The earliest next grant is at edge m+2.
- Throughput: one conversion per (converter latency + 4) cycles. Back-to-back requesters are never starved: worst-case wait is N_REQ-1 services.
- Timeout: o_Done/o_Timeout rise TIMEOUT_CYC cycles after entering WAIT.

## Test plan
- Reset: assert i_Reset_n=0 mid-idle and mid-WAIT -> all outputs 0 asynchronously. After release, i_Req=4'b1111 grants requester 0 first.
- Single request: i_Req=4'b0100, operand 1234 -> o_Grant=4'b0100, exactly one o_Conv_Start pulse, o_Done=4'b0100 for one cycle, o_BCD=16'h1234.
- Simultaneous requests after reset: operands {1, 8191, 5000, 999}, all requesters held until their own done -> service order 0,1,2,3. Results 16'h0001, 16'h8191, 16'h5000, 16'h0999. Each o_Done pulses once.
- Fairness: req0 held continuously, req3 asserted and reasserted after each done -> grants alternate 0,3,0,3. The gap between a DV edge and the next o_Conv_Start is exactly 2 cycles.
- Timeout: converter model never asserts DV -> after 255 WAIT cycles o_Timeout=1 and o_Done pulse together, o_BCD=16'hFFFF. A DV injected 10 cycles later is ignored (o_Done stays 0).
- Request drop: requester 1 drops i_Req during WAIT -> conversion completes, o_Done[1] pulses, and no second grant is issued to it.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among N_REQ requesters.
// Captures the winner's operand, pulses start, waits for data-valid or watchdog abort.
module bcd_conv_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned BIN_W       = 13,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic [N_REQ-1:0]          i_Req,
  input  logic [N_REQ*BIN_W-1:0]    i_Binary_Bus,
  output logic [N_REQ-1:0]          o_Grant,
  output logic [N_REQ-1:0]          o_Done,
  output logic [DIGITS*4-1:0]       o_BCD,
  output logic                      o_Timeout,
  output logic                      o_Busy,
  output logic [BIN_W-1:0]          o_Conv_Binary,
  output logic                      o_Conv_Start,
  input  logic [DIGITS*4-1:0]       i_Conv_BCD,
  input  logic                      i_Conv_DV
);

  localparam int unsigned LW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BCD_W = DIGITS * 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      last_q, last_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               start_q, start_d;

  logic [BIN_W-1:0]   operand [N_REQ];
  logic               found;
  logic [LW-1:0]      win;

  for (genvar k = 0; k < N_REQ; k++) begin : g_slice
    assign operand[k] = i_Binary_Bus[k*BIN_W +: BIN_W];
  end

  // Round-robin search starting just after the last winner, wrapping modulo N_REQ
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    win   = last_q;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(last_q) + i) % N_REQ;
      if (!found && i_Req[LW'(idx)]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    grant_d   = grant_q;
    done_d    = '0;
    bcd_d     = bcd_q;
    timeout_d = 1'b0;
    bin_d     = bin_q;
    start_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          bin_d        = operand[win];
          start_d      = 1'b1;
          last_d       = win;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wdog_q != WD_W'(TIMEOUT_CYC)) begin
          wdog_d = wdog_q + 1'b1;
        end
        // Data-valid takes priority over a coincident terminal count
        if (i_Conv_DV) begin
          bcd_d   = i_Conv_BCD;
          done_d  = grant_q;
          grant_d = '0;
          state_d = ST_DONE;
        end else if (wdog_q >= WD_W'(TIMEOUT_CYC - 1)) begin
          bcd_d     = '1;
          done_d    = grant_q;
          timeout_d = 1'b1;
          grant_d   = '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= ST_IDLE;
      last_q    <= LW'(N_REQ - 1);
      wdog_q    <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      bcd_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      bin_q     <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      bin_q     <= bin_d;
      start_q   <= start_d;
    end
  end

  assign o_Grant       = grant_q;
  assign o_Done        = done_q;
  assign o_BCD         = bcd_q;
  assign o_Timeout     = timeout_q;
  assign o_Busy        = busy_q;
  assign o_Conv_Binary = bin_q;
  assign o_Conv_Start  = start_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a fixed-latency behavioural converter.
module tb_bcd_conv_arbiter;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [51:0] bin_bus = '0;
  logic [3:0]  grant, done;
  logic [15:0] bcd;
  logic        timeout, busy, conv_start;
  logic [12:0] conv_binary;
  logic        conv_en = 1'b1;
  logic        force_dv = 1'b0;
  logic [15:0] force_bcd = '0;
  logic        model_dv;
  logic [15:0] model_bcd;
  logic [12:0] cap;
  int          cnt;
  logic        conv_dv;
  logic [15:0] conv_bcd;

  assign conv_dv  = model_dv | force_dv;
  assign conv_bcd = force_dv ? force_bcd : model_bcd;

  bcd_conv_arbiter dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Req(req), .i_Binary_Bus(bin_bus),
    .o_Grant(grant), .o_Done(done), .o_BCD(bcd), .o_Timeout(timeout), .o_Busy(busy),
    .o_Conv_Binary(conv_binary), .o_Conv_Start(conv_start),
    .i_Conv_BCD(conv_bcd), .i_Conv_DV(conv_dv)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input logic [12:0] b);
    int v;
    v = int'(b);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Converter: samples start, answers LAT cycles later with a one-cycle data-valid
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0; model_dv <= 1'b0; model_bcd <= '0; cap <= '0;
    end else begin
      model_dv <= 1'b0;
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          model_dv  <= 1'b1;
          model_bcd <= to_bcd(cap);
        end
      end else if (conv_start && conv_en) begin
        cnt <= LAT;
        cap <= conv_binary;
      end
    end
  end

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_start = 0, total_done = 0, n_timeout = 0, n_to_done = 0;
  int start_edge = 0, done_edge = 0, dv_edge = 0;
  bit dv_pending = 1'b0;
  int n_done [4] = '{default: 0};
  logic [15:0] res [4];
  logic [12:0] start_bin = '0;
  int order[$];
  int gaps[$];

  task automatic set_op(input int k, input logic [12:0] v);
    bin_bus[k*13 +: 13] = v;
  endtask

  // Advance to just after the falling edge and record what the DUT presents
  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    if (conv_start) begin
      n_start++;
      start_edge = cyc;
      start_bin  = conv_binary;
      for (int k = 0; k < 4; k++) if (grant[k]) order.push_back(k);
      if (dv_pending) begin
        gaps.push_back(cyc - dv_edge);
        dv_pending = 1'b0;
      end
    end
    if (conv_dv) begin
      dv_edge    = cyc + 1;
      dv_pending = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      if (done[k]) begin
        n_done[k]++;
        total_done++;
        res[k]    = bcd;
        done_edge = cyc;
      end
    end
    if (timeout) begin
      n_timeout++;
      if (done != '0) n_to_done++;
    end
  endtask

  // Requesters drop on their done (unless kept) and optionally re-raise one cycle later
  task automatic run_until(input int target, input int budget, input logic [3:0] keep,
                           input logic [3:0] reassert, output bit ok);
    int base;
    logic [3:0] pend;
    base = total_done;
    pend = '0;
    ok   = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      req  = req | pend;
      pend = '0;
      if (done != '0) begin
        req  = req & ~(done & ~keep);
        pend = done & reassert;
      end
      if (total_done - base >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0)        begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (done !== 4'b0)         begin n_err++; $display("FAIL reset_done: got %b want 0000", done); end
    n_cmp++; if (bcd !== 16'h0)         begin n_err++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
    n_cmp++; if (timeout !== 1'b0)      begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (conv_binary !== 13'd0) begin n_err++; $display("FAIL reset_conv_binary: got %0d want 0", conv_binary); end
    n_cmp++; if (conv_start !== 1'b0)   begin n_err++; $display("FAIL reset_conv_start: got %b want 0", conv_start); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int s0, d0, t0;
    logic [3:0] got_grant, got_done;
    bit saw_busy;
    s0 = n_start; d0 = n_done[2]; t0 = n_timeout;
    got_grant = '0; got_done = '0; saw_busy = 1'b0;
    set_op(2, 13'd1234);
    req = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (got_grant == '0 && grant != '0) got_grant = grant;
      if (busy) saw_busy = 1'b1;
      if (done != '0) begin
        got_done = done;
        req = '0;
        break;
      end
    end
    repeat (3) tick();
    n_cmp++; if (got_grant !== 4'b0100)  begin n_err++; $display("FAIL single_grant: got %b want 0100", got_grant); end
    n_cmp++; if (start_bin !== 13'd1234) begin n_err++; $display("FAIL single_operand: got %0d want 1234", start_bin); end
    n_cmp++; if (n_start - s0 != 1)      begin n_err++; $display("FAIL single_start_count: got %0d want 1", n_start - s0); end
    n_cmp++; if (got_done !== 4'b0100)   begin n_err++; $display("FAIL single_done: got %b want 0100", got_done); end
    n_cmp++; if (n_done[2] - d0 != 1)    begin n_err++; $display("FAIL single_done_count: got %0d want 1", n_done[2] - d0); end
    n_cmp++; if (bcd !== 16'h1234)       begin n_err++; $display("FAIL single_bcd: got %h want 1234", bcd); end
    n_cmp++; if (done_edge - start_edge != LAT + 2) begin n_err++; $display("FAIL single_latency: got %0d want %0d", done_edge - start_edge, LAT + 2); end
    n_cmp++; if (!saw_busy || busy !== 1'b0) begin n_err++; $display("FAIL single_busy: saw %b end %b want 1/0", saw_busy, busy); end
    n_cmp++; if (n_timeout != t0)        begin n_err++; $display("FAIL single_no_timeout: got %0d want 0", n_timeout - t0); end
  endtask

  task automatic test_reset_async();
    bit seen;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bcd !== 16'h0) begin n_err++; $display("FAIL idle_reset_bcd: got %h want 0000", bcd); end
    tick();
    rst_n = 1'b1;
    tick();
    conv_en = 1'b0;
    set_op(0, 13'd55);
    req = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (grant == 4'b0001) seen = 1'b1;
    end
    repeat (5) tick();
    n_cmp++; if (!seen || busy !== 1'b1) begin n_err++; $display("FAIL wait_before_reset: grant_seen %b busy %b want 1/1", seen, busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL wait_reset_grant_busy: got %b/%b want 0000/0", grant, busy); end
    n_cmp++; if (conv_binary !== 13'd0 || conv_start !== 1'b0) begin n_err++; $display("FAIL wait_reset_conv: got %0d/%b want 0/0", conv_binary, conv_start); end
    req = '0;
    repeat (2) tick();
    conv_en = 1'b1;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    int o0, d0 [4];
    bit ok;
    logic [15:0] exp_res [4];
    int exp_ord [4];
    exp_res = '{16'h0001, 16'h8191, 16'h5000, 16'h0999};
    exp_ord = '{0, 1, 2, 3};
    for (int k = 0; k < 4; k++) d0[k] = n_done[k];
    set_op(0, 13'd1); set_op(1, 13'd8191); set_op(2, 13'd5000); set_op(3, 13'd999);
    o0 = order.size();
    req = 4'b1111;
    run_until(4, 100, 4'b0000, 4'b0000, ok);
    repeat (3) tick();
    n_cmp++; if (!ok) begin n_err++; $display("FAIL simul_budget: got %0d dones want 4", total_done); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (order.size() <= o0 + i || order[o0 + i] != exp_ord[i]) begin
        n_err++; $display("FAIL simul_order[%0d]: got %0d want %0d", i, (order.size() > o0 + i) ? order[o0 + i] : -1, exp_ord[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (res[k] !== exp_res[k] || n_done[k] - d0[k] != 1) begin
        n_err++; $display("FAIL simul_result[%0d]: got %h x%0d want %h x1", k, res[k], n_done[k] - d0[k], exp_res[k]);
      end
    end
  endtask

  task automatic test_fairness();
    int o0;
    bit ok;
    int exp_ord [4];
    exp_ord = '{0, 3, 0, 3};
    set_op(0, 13'd42); set_op(3, 13'd7);
    o0 = order.size();
    req = 4'b1001;
    run_until(4, 100, 4'b0001, 4'b1000, ok);
    req = '0;
    repeat (4) tick();
    n_cmp++; if (!ok) begin n_err++; $display("FAIL fair_budget: got %0d dones want 4", total_done); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (order.size() <= o0 + i || order[o0 + i] != exp_ord[i]) begin
        n_err++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, (order.size() > o0 + i) ? order[o0 + i] : -1, exp_ord[i]);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      n_cmp++;
      if (gaps.size() < 3 || gaps[gaps.size() - i] != 2) begin
        n_err++; $display("FAIL fair_gap[%0d]: got %0d want 2", i, (gaps.size() >= i) ? gaps[gaps.size() - i] : -1);
      end
    end
  endtask

  task automatic test_timeout();
    int t0, c0, td0;
    bit ok;
    t0 = n_timeout; c0 = n_to_done;
    conv_en = 1'b0;
    set_op(1, 13'd77);
    req = 4'b0010;
    run_until(1, 400, 4'b0000, 4'b0000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL timeout_budget: no done within 400 cycles"); end
    n_cmp++; if (n_timeout - t0 != 1 || n_to_done - c0 != 1) begin n_err++; $display("FAIL timeout_pulse: got %0d/%0d want 1/1", n_timeout - t0, n_to_done - c0); end
    n_cmp++; if (done_edge - start_edge != 256) begin n_err++; $display("FAIL timeout_cycles: got %0d want 256", done_edge - start_edge); end
    n_cmp++; if (bcd !== 16'hFFFF) begin n_err++; $display("FAIL timeout_bcd: got %h want ffff", bcd); end
    td0 = total_done;
    repeat (9) tick();
    force_bcd = 16'h4321;
    force_dv  = 1'b1;
    tick();
    force_dv  = 1'b0;
    repeat (4) tick();
    n_cmp++; if (total_done != td0) begin n_err++; $display("FAIL late_dv_done: got %0d extra want 0", total_done - td0); end
    n_cmp++; if (bcd !== 16'hFFFF || busy !== 1'b0) begin n_err++; $display("FAIL late_dv_state: got %h/%b want ffff/0", bcd, busy); end
    conv_en = 1'b1;
  endtask

  task automatic test_req_drop();
    int s0, d0;
    bit seen, ok;
    s0 = n_start; d0 = n_done[1];
    set_op(1, 13'd321);
    req = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (grant == 4'b0010) seen = 1'b1;
    end
    repeat (2) tick();
    req = '0;
    run_until(1, 30, 4'b0000, 4'b0000, ok);
    repeat (10) tick();
    n_cmp++; if (!seen || !ok) begin n_err++; $display("FAIL drop_complete: grant %b done %b want 1/1", seen, ok); end
    n_cmp++; if (n_done[1] - d0 != 1) begin n_err++; $display("FAIL drop_done_count: got %0d want 1", n_done[1] - d0); end
    n_cmp++; if (bcd !== 16'h0321) begin n_err++; $display("FAIL drop_bcd: got %h want 0321", bcd); end
    n_cmp++; if (n_start - s0 != 1 || grant !== 4'b0) begin n_err++; $display("FAIL drop_regrant: starts %0d grant %b want 1/0000", n_start - s0, grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_async();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_req_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
